delay_seq_gen: RTL and testbench
================================

# delay_seq_gen

Multi-channel power-on/enable sequencer and the parametrised successor of the single-channel delay generator. It releases `NUM_CH` enables one after another, each after its own programmable delay counted on `real_time_clk_i`. Optionally it withdraws them in reverse order. It sits after system reset, ahead of blocks that must come up in a fixed order, such as PLL, memories, peripherals and the core.

## Interface
- `NUM_CH`, default 4: number of sequenced channels, at least 1.
- `CNT_W`, default 16: width of each per-channel delay and of the internal counter.

- `arst_ni`, input, 1: asynchronous, active-low reset.
- `real_time_clk_i`, input, 1: sequencing clock; all logic and outputs are in this domain.
- `enable_i`, input, 1: request to sequence up (1) or down (0). Asynchronous; synchronised internally by 2 flops.
- `delay_i`, input, `NUM_CH*CNT_W`: per-channel delay in cycles; channel k occupies bits `[k*CNT_W +: CNT_W]`.
- `enable_o`, output, `NUM_CH`: sequenced enables; bit k is channel k.
- `busy_o`, output, 1: high while in UP or DOWN.
- `all_on_o`, output, 1: high while in ON.

## Operation
- States: IDLE, UP, ON, DOWN (DOWN exists only with the macro, see Configuration).
- `en_s` is `enable_i` after the 2-flop synchroniser.
- Internal registers:
  - `cnt`: `CNT_W` bits.
  - `idx`: `$clog2(NUM_CH)` bits, minimum 1.
  - `dly_q`: `NUM_CH*CNT_W`.

**IDLE**
- `enable_o` is all 0.
- On `en_s`=1: latch `delay_i` into `dly_q`, set `cnt`=0 and `idx`=0, go to UP.

**UP**
- If `cnt`==`dly_q[idx]`: set `enable_o[idx]`=1 and `cnt`=0.
  - If `idx`==`NUM_CH-1`, go to ON.
  - Otherwise `idx`++.
- Else `cnt`++.

**ON**
- Hold all enables at 1.
- On `en_s`=0: go to the disable path.

**Disable path**
- Taken from UP or ON when `en_s`=0.
- If no channel is yet asserted, in UP with `idx`=0: go to IDLE immediately.
- Otherwise behaviour is as given under Configuration.

**Rules**
- A delay of 0 releases the channel on the first counting cycle.
- Maximum delay is 2^`CNT_W`-1. `cnt` is cleared on each match and never wraps.
- `delay_i` changes after the latch edge are ignored until the next IDLE exit.
- `en_s` reasserting during DOWN does not abort it. DOWN completes, then IDLE, then UP restarts on the next cycle if `en_s` is still 1.
- Asserted channels always form a contiguous prefix `enable_o[0..m]`. No other pattern occurs.

## Timing
- Reset: all synchroniser flops, `cnt`, `idx` and `dly_q` are 0; state is IDLE. `enable_o`=0, `busy_o`=0, `all_on_o`=0.
- Reset mid-sequence clears everything asynchronously, with no reverse sequencing.
- Up latency:
  - If `enable_i` is first sampled high at edge S, the state leaves IDLE at edge S+2.
  - `enable_o[k]` rises at edge S+2+Σ_{j≤k}(`dly_q[j]`+1).
  - `all_on_o` rises on the same edge as `enable_o[NUM_CH-1]`.
- Down entry: if `enable_i` is first sampled low at edge D, UP/ON exits at edge D+2.
- Outputs are registered and glitch-free; `busy_o` and `all_on_o` are registered state decodes.

## Configuration
Macro: `DELAY_SEQ_GEN_REVERSE_OFF_EN`.

**Defined**
- The disable path enters DOWN with `cnt`=0 and `idx` set to the highest asserted channel.
- In DOWN, when `cnt`==`dly_q[idx]`: clear `enable_o[idx]` and set `cnt`=0.
  - If `idx`==0, go to IDLE.
  - Otherwise `idx`--.
- Else `cnt`++.
- Channel k therefore drops `dly_q[k]`+1 cycles after the channel above it, or after DOWN entry for the highest asserted channel.

**Undefined**
- DOWN is absent.
- The disable path clears all `enable_o` bits on the exit edge (D+2) and goes to IDLE.

## Test plan
All scenarios use `NUM_CH`=4, `CNT_W`=8, delays {2,0,5,3}, with `enable_i` first sampled high at edge S and first sampled low at edge D.
- Power-up: `enable_i` rises → `enable_o[0..3]` rise at S+5, S+6, S+12, S+16; `all_on_o` at S+16; `busy_o` high S+2..S+15.
- Reverse off (macro defined): `enable_i` falls while in ON → `enable_o[3..0]` fall at D+6, D+12, D+13, D+16; IDLE at D+16.
- Flat off (macro undefined): `enable_i` falls while in ON → all `enable_o` clear at D+2; `busy_o` stays 0.
- Abort: `enable_i` falls while only `enable_o[0]`=1 (macro defined) → channel 0 clears 3 cycles after DOWN entry; `enable_o[1]` never asserts.
- Delay latch: `delay_i` changes to all 0 at S+3 → timings identical to power-up scenario.
- Async reset asserted mid-UP and mid-DOWN → all outputs 0 immediately; the next `enable_i` rise restarts at channel 0 with the S+5 timing.

Source files
------------

// File: rtl/delay_seq_gen.sv
// Multi-channel enable sequencer: releases NUM_CH enables in order, each after its own delay.
// Optional reverse-order withdrawal is enabled by defining DELAY_SEQ_GEN_REVERSE_OFF_EN.
module delay_seq_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    arst_ni,
  input  logic                    real_time_clk_i,
  input  logic                    enable_i,
  input  logic [NUM_CH*CNT_W-1:0] delay_i,
  output logic [NUM_CH-1:0]       enable_o,
  output logic                    busy_o,
  output logic                    all_on_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
`ifdef DELAY_SEQ_GEN_REVERSE_OFF_EN
    DOWN = 2'd3,
`endif
    ON   = 2'd2
  } state_t;

  state_t                  state;
  logic                    sync1_q;
  logic                    en_s;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [NUM_CH*CNT_W-1:0] dly_q;

  logic [CNT_W-1:0]  dly_arr [NUM_CH];
  logic [CNT_W-1:0]  cur_dly;
  logic              cnt_hit;
  logic [NUM_CH-1:0] idx_bit;

  always_ff @(posedge real_time_clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      sync1_q <= 1'b0;
      en_s    <= 1'b0;
    end else begin
      sync1_q <= enable_i;
      en_s    <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dly
    assign dly_arr[gi] = dly_q[gi*CNT_W +: CNT_W];
  end

  assign cur_dly = dly_arr[idx];
  assign cnt_hit = (cnt == cur_dly);
  assign idx_bit = NUM_CH'(1) << idx;

  always_ff @(posedge real_time_clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      dly_q    <= '0;
      enable_o <= '0;
      busy_o   <= 1'b0;
      all_on_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          enable_o <= '0;
          if (en_s) begin
            dly_q  <= delay_i;
            cnt    <= '0;
            idx    <= '0;
            busy_o <= 1'b1;
            state  <= UP;
          end
        end

        UP: begin
          // Disable request wins over a coincident counter match.
          if (!en_s) begin
            if (idx == '0) begin
              enable_o <= '0;
              busy_o   <= 1'b0;
              state    <= IDLE;
            end else begin
`ifdef DELAY_SEQ_GEN_REVERSE_OFF_EN
              // Channels 0..idx-1 are up; start withdrawing from the top one.
              cnt   <= '0;
              idx   <= idx - 1'b1;
              state <= DOWN;
`else
              enable_o <= '0;
              busy_o   <= 1'b0;
              state    <= IDLE;
`endif
            end
          end else if (cnt_hit) begin
            enable_o <= enable_o | idx_bit;
            cnt      <= '0;
            if (idx == LAST_IDX) begin
              busy_o   <= 1'b0;
              all_on_o <= 1'b1;
              state    <= ON;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ON: begin
          enable_o <= '1;
          if (!en_s) begin
            all_on_o <= 1'b0;
`ifdef DELAY_SEQ_GEN_REVERSE_OFF_EN
            busy_o <= 1'b1;
            cnt    <= '0;
            idx    <= LAST_IDX;
            state  <= DOWN;
`else
            enable_o <= '0;
            state    <= IDLE;
`endif
          end
        end

`ifdef DELAY_SEQ_GEN_REVERSE_OFF_EN
        // en_s is deliberately ignored here: a started shutdown always completes.
        DOWN: begin
          if (cnt_hit) begin
            enable_o <= enable_o & ~idx_bit;
            cnt      <= '0;
            if (idx == '0) begin
              busy_o <= 1'b0;
              state  <= IDLE;
            end else begin
              idx <= idx - 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_seq_gen.sv
// Directed bench for delay_seq_gen: NUM_CH=4, CNT_W=8, delays {2,0,5,3}; checks are edge offsets from S or D.
module tb_delay_seq_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                    arst_ni = 1'b0;
  logic                    clk = 1'b0;
  logic                    enable_i = 1'b0;
  logic [NUM_CH*CNT_W-1:0] delay_i;
  logic [NUM_CH-1:0]       enable_o;
  logic                    busy_o;
  logic                    all_on_o;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  typedef struct {
    int         off;
    logic [3:0] en;
    logic       busy;
    logic       all_on;
  } vec_t;

  vec_t up_tbl[$];
  vec_t latch_tbl[$];
  vec_t dn_tbl[$];
  vec_t ab_tbl[$];
  vec_t rst_tbl[$];

  delay_seq_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .arst_ni         (arst_ni),
    .real_time_clk_i (clk),
    .enable_i        (enable_i),
    .delay_i         (delay_i),
    .enable_o        (enable_o),
    .busy_o          (busy_o),
    .all_on_o        (all_on_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  function automatic vec_t mk(int off, logic [3:0] en, logic busy, logic all_on);
    vec_t r;
    r.off = off;
    r.en = en;
    r.busy = busy;
    r.all_on = all_on;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [3:0] en, logic busy, logic all_on);
    n_cmp++;
    if ({enable_o, busy_o, all_on_o} !== {en, busy, all_on}) begin
      n_bad++;
      $display("FAIL %s: got en=%b busy=%b all_on=%b, want en=%b busy=%b all_on=%b",
               name, enable_o, busy_o, all_on_o, en, busy, all_on);
    end else begin
      $display("ok   %s: en=%b busy=%b all_on=%b", name, enable_o, busy_o, all_on_o);
    end
  endtask

  task automatic run_tbl(string tag, int base, vec_t tbl[$]);
    foreach (tbl[i]) begin
      if (edge_n > base + tbl[i].off) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s@+%0d: sample point already passed (edge %0d)", tag, tbl[i].off, edge_n);
      end
      while (edge_n < base + tbl[i].off) step();
      check($sformatf("%s@+%0d", tag, tbl[i].off), tbl[i].en, tbl[i].busy, tbl[i].all_on);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int d;
    logic [NUM_CH*CNT_W-1:0] dly_nom;

    dly_nom = {8'd3, 8'd5, 8'd0, 8'd2};
    delay_i = dly_nom;

    up_tbl = '{mk(1, 4'b0000, 0, 0), mk(2, 4'b0000, 1, 0), mk(4, 4'b0000, 1, 0),
               mk(5, 4'b0001, 1, 0), mk(6, 4'b0011, 1, 0), mk(11, 4'b0011, 1, 0),
               mk(12, 4'b0111, 1, 0), mk(15, 4'b0111, 1, 0), mk(16, 4'b1111, 0, 1),
               mk(20, 4'b1111, 0, 1)};
    foreach (up_tbl[i]) if (up_tbl[i].off >= 3) latch_tbl.push_back(up_tbl[i]);
    rst_tbl = '{mk(4, 4'b0000, 1, 0), mk(5, 4'b0001, 1, 0), mk(6, 4'b0011, 1, 0)};
`ifdef DELAY_SEQ_GEN_REVERSE_OFF_EN
    dn_tbl = '{mk(1, 4'b1111, 0, 1), mk(2, 4'b1111, 1, 0), mk(5, 4'b1111, 1, 0),
               mk(6, 4'b0111, 1, 0), mk(11, 4'b0111, 1, 0), mk(12, 4'b0011, 1, 0),
               mk(13, 4'b0001, 1, 0), mk(15, 4'b0001, 1, 0), mk(16, 4'b0000, 0, 0),
               mk(19, 4'b0000, 0, 0)};
    ab_tbl = '{mk(5, 4'b0001, 1, 0), mk(6, 4'b0001, 1, 0), mk(7, 4'b0001, 1, 0),
               mk(8, 4'b0001, 1, 0), mk(9, 4'b0000, 0, 0), mk(12, 4'b0000, 0, 0)};
`else
    dn_tbl = '{mk(1, 4'b1111, 0, 1), mk(2, 4'b0000, 0, 0), mk(3, 4'b0000, 0, 0),
               mk(6, 4'b0000, 0, 0)};
    ab_tbl = '{mk(5, 4'b0001, 1, 0), mk(6, 4'b0000, 0, 0), mk(7, 4'b0000, 0, 0),
               mk(9, 4'b0000, 0, 0)};
`endif

    step(); step();
    check("reset", 4'b0000, 0, 0);
    arst_ni = 1'b1;
    step(); step();
    check("idle", 4'b0000, 0, 0);

    // Power-up then shutdown from ON.
    enable_i = 1'b1; s = edge_n + 1;
    run_tbl("up", s, up_tbl);
    enable_i = 1'b0; d = edge_n + 1;
    run_tbl("off", d, dn_tbl);
    repeat (25) step();

    // delay_i changes after the latch edge must not affect timing.
    enable_i = 1'b1; s = edge_n + 1;
    while (edge_n < s + 2) step();
    delay_i = '0;
    run_tbl("latch", s, latch_tbl);
    delay_i = dly_nom;
    enable_i = 1'b0;
    repeat (25) step();

    // Disable while only channel 0 is up (exit lands at S+6).
    enable_i = 1'b1; s = edge_n + 1;
    while (edge_n < s + 3) step();
    enable_i = 1'b0;
    run_tbl("abort", s, ab_tbl);
    repeat (5) step();

    // Async reset mid-UP, then restart from channel 0.
    enable_i = 1'b1; s = edge_n + 1;
    while (edge_n < s + 8) step();
    check("midup_pre", 4'b0011, 1, 0);
    #2 arst_ni = 1'b0;
    #1 check("rst_midup", 4'b0000, 0, 0);
    enable_i = 1'b0;
    step(); step();
    arst_ni = 1'b1;
    step(); step(); step();
    enable_i = 1'b1; s = edge_n + 1;
    run_tbl("restart1", s, rst_tbl);

    // Async reset during shutdown (mid-DOWN when reverse-off is built in).
    while (edge_n < s + 20) step();
    enable_i = 1'b0; d = edge_n + 1;
`ifdef DELAY_SEQ_GEN_REVERSE_OFF_EN
    while (edge_n < d + 8) step();
    check("middown_pre", 4'b0111, 1, 0);
`else
    while (edge_n < d + 1) step();
    check("middown_pre", 4'b1111, 0, 1);
`endif
    #2 arst_ni = 1'b0;
    #1 check("rst_middown", 4'b0000, 0, 0);
    step(); step();
    arst_ni = 1'b1;
    step(); step(); step();
    enable_i = 1'b1; s = edge_n + 1;
    run_tbl("restart2", s, rst_tbl);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
